btn_operand_capture: RTL and testbench
======================================

Name: btn_operand_capture

Overview:
- Producer side of the operand interface consumed by the arithmetic/FSM logic in the top level.
- Reads the 4 board switches:
  - switches[2:0] carry the operand value.
  - switches[3] is the ENTER button.
- Synchronises and debounces the switches, then captures two 3-bit operands on successive ENTER presses.
- Presents the pair as in1/in2 with a valid/ack handshake. The phase is exposed for LED debug.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive identical synchronised samples required before the debounced vector updates. Minimum 2; board builds override to about 500000.
- WIDTH, 3: operand width. Must be ≤3, because the data field is switches[2:0].

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- switches, input, 4: raw board switches. Bit 3 = ENTER, bits 2:0 = data.
- ack, input, 1: consumer has taken in1/in2. Sampled only while valid=1.
- in1, output, WIDTH: first operand.
- in2, output, WIDTH: second operand.
- valid, output, 1: in1/in2 form a complete pair.
- phase, output, 2: state encoding. 0 = WAIT_OP1, 1 = WAIT_OP2, 2 = HOLD.

Behaviour:
- Reset is asynchronous and active-high on clock clk. During and after reset:
  - in1=0, in2=0, valid=0, phase=0.
  - Sync flops, candidate, counter, debounced vector db and db_prev all 0.
- Synchroniser: 2-flop synchroniser on all 4 bits, producing s[3:0].
- Debounce is whole-vector. Each cycle:
  - if s≠cand: cand←s, cnt←0;
  - else if cnt==DEBOUNCE_CYCLES-1: db←cand, cnt holds (saturates);
  - else cnt←cnt+1.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Edge detect:
  - db_prev←db every cycle.
  - press = db[3] & ~db_prev[3], combinational from registers, 1 cycle wide.
  - Falling edges are ignored.
- Latency: from a switches change held stable to db update = 2 sync + 1 + DEBOUNCE_CYCLES cycles. press is asserted in the cycle after db updates.
- FSM (registered):
  - WAIT_OP1 & press: in1←db[WIDTH-1:0], go to WAIT_OP2.
  - WAIT_OP2 & press: in2←db[WIDTH-1:0], valid←1, go to HOLD.
  - HOLD & ack: valid←0, go to WAIT_OP1. in1/in2 keep their values until overwritten.
  - HOLD & press (no ack): press is dropped; state and operands are unchanged.
- Simultaneous ack and press in HOLD: ack wins and the press is dropped. The FSM is in WAIT_OP1 the next cycle.
- ack outside HOLD is ignored.
- Data bits are debounced together with ENTER. Data set before ENTER is therefore already stable when the press occurs.
- Reset mid-operation aborts any partial capture; all outputs return to their reset values.
- If ENTER is held through reset release, db rises after debounce and generates a press. This is required behaviour.
- phase is driven directly from the state register.

Optional Feature:
- Macro: BTN_CAPTURE_OVERRUN_EN.
- Defined:
  - Adds output port overrun, 1 bit, reset 0.
  - overrun is set sticky on any press dropped in HOLD.
  - overrun is cleared by reset or by an accepted ack.
  - If ack and press occur in the same cycle, the clear wins.
- Undefined: the port is absent and dropped presses are silent.

Decomposition:
- Package btn_capture_pkg holds:
  - the phase localparams (PH_WAIT_OP1=2'd0, PH_WAIT_OP2=2'd1, PH_HOLD=2'd2);
  - a clog2 constant function for the counter width.
- Sub-module btn_debounce, parameter DEBOUNCE_CYCLES:
  - 4-bit synchroniser plus the debounce counter;
  - outputs db[3:0].
- The top FSM, edge detect and capture registers stay in btn_operand_capture.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset → in1=0, in2=0, valid=0, phase=0. With switches=4'b1111 asserted during reset, outputs stay 0 while reset is high.
- Normal capture:
  - switches=4'b0101, then 4'b1101, then release to 4'b0101 → phase=1 and in1=3'd5.
  - switches=4'b0011, press ENTER → in2=3'd3, valid=1, phase=2.
  - ack=1 for 1 cycle → valid=0 and phase=0 the next cycle; in1=5 and in2=3 retained.
  - Capture latency: press is asserted DEBOUNCE_CYCLES+3 cycles after a stable switches change.
- Bounce: toggle switches[3] every 2 cycles for 20 cycles, then hold 0 → no press, phase unchanged.
- HOLD overrun: in HOLD, press ENTER with data=3'd7 → in1/in2 unchanged, valid stays 1. With the macro defined, overrun=1; then ack → overrun=0, valid=0.
- ack and press in the same cycle in HOLD → phase=0, in1 unchanged, overrun=0.
- Reset mid-op: press once (phase=1), assert reset for 1 cycle → phase=0, in1=0. Then two presses give a fresh pair.

Source files
------------

// File: rtl/btn_capture_pkg.sv
// Shared constants for the switch operand-capture block: phase encodings
// and the counter-width helper used by the debouncer.
package btn_capture_pkg;

  localparam logic [1:0] PH_WAIT_OP1 = 2'd0;
  localparam logic [1:0] PH_WAIT_OP2 = 2'd1;
  localparam logic [1:0] PH_HOLD     = 2'd2;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and whole-vector debouncer for the 4 board switches.
// db only changes once the synchronised vector has been identical for
// DEBOUNCE_CYCLES+1 consecutive samples, so data bits and ENTER settle together.
module btn_debounce
  import btn_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] switches,
  output logic [3:0] db
);

  localparam int             CW      = clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0][3:0] sync_q;
  logic [3:0]      s;
  logic [3:0]      cand;
  logic [CW-1:0]   cnt;

  assign s = sync_q[1];

  // Bring the asynchronous switch levels into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else begin
      sync_q[0] <= switches;
      sync_q[1] <= sync_q[0];
    end
  end

  // Any change restarts the stability count; a saturated count commits cand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand <= '0;
      cnt  <= '0;
      db   <= '0;
    end else if (s != cand) begin
      cand <= s;
      cnt  <= '0;
    end else if (cnt == CNT_MAX) begin
      db   <= cand;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/btn_operand_capture.sv
// Captures two operands from the board switches on successive ENTER presses
// and presents them as a valid/ack pair. phase mirrors the state register.
// Optional: define BTN_CAPTURE_OVERRUN_EN to add a sticky overrun flag that
// records presses dropped while a pair is waiting to be taken.
// WIDTH must not exceed 3: the data field is switches[2:0].
module btn_operand_capture
  import btn_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WIDTH           = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       switches,
  input  logic             ack,
  output logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] in2,
  output logic             valid,
  output logic [1:0]       phase
`ifdef BTN_CAPTURE_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  logic [3:0] db;
  logic [3:0] db_prev;
  logic       press;
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       ld_in1;
  logic       ld_in2;
  logic       accept;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
    .db       (db)
  );

  // Previous debounced vector for rising-edge detection of ENTER.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) db_prev <= '0;
    else       db_prev <= db;
  end

  // One-cycle strobe on a debounced ENTER rising edge; releases are ignored.
  assign press = db[3] & ~db_prev[3];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= PH_WAIT_OP1;
    else       state_q <= state_d;
  end

  // Next state: ack in HOLD takes priority, so a coincident press is lost.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_WAIT_OP1: if (press) state_d = PH_WAIT_OP2;
      PH_WAIT_OP2: if (press) state_d = PH_HOLD;
      PH_HOLD:     if (ack)   state_d = PH_WAIT_OP1;
      default:                state_d = PH_WAIT_OP1;
    endcase
  end

  // Output decode: load strobes for the capture registers.
  always_comb begin
    ld_in1 = (state_q == PH_WAIT_OP1) & press;
    ld_in2 = (state_q == PH_WAIT_OP2) & press;
    accept = (state_q == PH_HOLD) & ack;
  end

  // Operand and valid registers; operands persist until the next capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in1   <= '0;
      in2   <= '0;
      valid <= 1'b0;
    end else begin
      if (ld_in1) in1 <= db[WIDTH-1:0];
      if (ld_in2) in2 <= db[WIDTH-1:0];
      if (ld_in2)      valid <= 1'b1;
      else if (accept) valid <= 1'b0;
    end
  end

  assign phase = state_q;

`ifdef BTN_CAPTURE_OVERRUN_EN
  logic dropped;
  assign dropped = (state_q == PH_HOLD) & press & ~ack;

  // Sticky flag for presses lost in HOLD; an accepted ack clears it first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overrun <= 1'b0;
    else if (accept)  overrun <= 1'b0;
    else if (dropped) overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_btn_operand_capture.sv
// Bench for btn_operand_capture with DEBOUNCE_CYCLES=4: directed scenarios
// against fixed values plus randomized switches/ack against a reference model.
module tb_btn_operand_capture;

  localparam int DC = 4;
  localparam int HN = DC + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] switches = 4'b0;
  logic       ack = 1'b0;
  logic [2:0] in1, in2;
  logic       valid;
  logic [1:0] phase;
`ifdef BTN_CAPTURE_OVERRUN_EN
  logic       overrun;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] hist [HN];
  logic [3:0] m_db, m_dbp;
  logic [1:0] m_phase;
  logic [2:0] m_in1, m_in2;
  logic       m_valid, m_ovr, m_press_next;

  btn_operand_capture #(
    .DEBOUNCE_CYCLES(DC),
    .WIDTH(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
    .ack      (ack),
    .in1      (in1),
    .in2      (in2),
    .valid    (valid),
    .phase    (phase)
`ifdef BTN_CAPTURE_OVERRUN_EN
    ,
    .overrun  (overrun)
`endif
  );

  always #5 clk = ~clk;

  // One clock: advance the model on the rising edge, return at the falling edge.
  // The model's debounced value is "the synchronised sample of the last DC+1
  // clocks, if they all agree", the synchronised sample being the switches
  // seen two clocks earlier.
  task automatic tick();
    logic press;
    logic [3:0] odb;
    logic eq;
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < HN; k++) hist[k] = 4'b0;
      m_db = 0; m_dbp = 0; m_phase = 0; m_in1 = 0; m_in2 = 0;
      m_valid = 0; m_ovr = 0;
    end else begin
      for (int k = HN - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = switches;
      press = m_db[3] & ~m_dbp[3];
      odb = m_db;
      eq = 1'b1;
      for (int k = 2; k <= 2 + DC; k++) if (hist[k] !== hist[2]) eq = 1'b0;
      m_dbp = m_db;
      if (eq) m_db = hist[2];
      case (m_phase)
        2'd0: if (press) begin m_in1 = odb[2:0]; m_phase = 2'd1; end
        2'd1: if (press) begin m_in2 = odb[2:0]; m_valid = 1'b1; m_phase = 2'd2; end
        default: begin
          if (ack) begin m_valid = 1'b0; m_phase = 2'd0; m_ovr = 1'b0; end
          else if (press) m_ovr = 1'b1;
        end
      endcase
    end
    m_press_next = m_db[3] & ~m_dbp[3];
    @(negedge clk);
  endtask

  task automatic press_enter(input logic [2:0] d);
    switches = {1'b1, d};
    repeat (10) tick();
    switches = {1'b0, d};
    repeat (10) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    switches = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({in1, in2, valid, phase} !== 9'b0) begin
        errors++;
        $display("FAIL reset_outputs got in1=%0d in2=%0d valid=%0d phase=%0d exp all 0",
                 in1, in2, valid, phase);
      end
    end
    // ENTER held through release must still produce a press.
    reset = 1'b0;
    repeat (12) tick();
    checks++;
    if (phase !== 2'd1 || in1 !== 3'd7) begin
      errors++;
      $display("FAIL enter_through_reset got phase=%0d in1=%0d exp phase=1 in1=7", phase, in1);
    end
    reset = 1'b1;
    switches = 4'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    checks++;
    if (phase !== 2'd0 || in1 !== 3'd0) begin
      errors++;
      $display("FAIL reset_clear got phase=%0d in1=%0d exp 0 0", phase, in1);
    end
  endtask

  task automatic test_capture();
    int n;
    switches = 4'b0101;
    repeat (10) tick();
    switches = 4'b1101;
    n = 0;
    while (phase !== 2'd1 && n < 50) begin tick(); n++; end
    checks++;
    if (n != DC + 4) begin
      errors++;
      $display("FAIL capture_latency got %0d clocks exp %0d", n, DC + 4);
    end
    repeat (4) tick();
    switches = 4'b0101;
    repeat (10) tick();
    checks++;
    if (phase !== 2'd1 || in1 !== 3'd5 || valid !== 1'b0) begin
      errors++;
      $display("FAIL capture_op1 got phase=%0d in1=%0d valid=%0d exp 1 5 0", phase, in1, valid);
    end
    switches = 4'b0011;
    repeat (10) tick();
    press_enter(3'd3);
    checks++;
    if (phase !== 2'd2 || in2 !== 3'd3 || valid !== 1'b1) begin
      errors++;
      $display("FAIL capture_op2 got phase=%0d in2=%0d valid=%0d exp 2 3 1", phase, in2, valid);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (phase !== 2'd0 || valid !== 1'b0 || in1 !== 3'd5 || in2 !== 3'd3) begin
      errors++;
      $display("FAIL capture_ack got phase=%0d valid=%0d in1=%0d in2=%0d exp 0 0 5 3",
               phase, valid, in1, in2);
    end
  endtask

  task automatic test_bounce();
    switches = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      switches[3] = ~switches[3];
      tick();
      tick();
      checks++;
      if (phase !== 2'd0) begin
        errors++;
        $display("FAIL bounce_phase got %0d exp 0 at toggle %0d", phase, i);
      end
    end
    switches = 4'b0011;
    repeat (10) tick();
    checks++;
    if (phase !== 2'd0 || in1 !== 3'd5) begin
      errors++;
      $display("FAIL bounce_settle got phase=%0d in1=%0d exp 0 5", phase, in1);
    end
  endtask

  task automatic test_overrun();
    press_enter(3'd1);
    press_enter(3'd2);
    press_enter(3'd7);
    checks++;
    if (phase !== 2'd2 || valid !== 1'b1 || in1 !== 3'd1 || in2 !== 3'd2) begin
      errors++;
      $display("FAIL hold_drop got phase=%0d valid=%0d in1=%0d in2=%0d exp 2 1 1 2",
               phase, valid, in1, in2);
    end
`ifdef BTN_CAPTURE_OVERRUN_EN
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %0d exp 1", overrun);
    end
`endif
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || phase !== 2'd0) begin
      errors++;
      $display("FAIL overrun_ack got valid=%0d phase=%0d exp 0 0", valid, phase);
    end
`ifdef BTN_CAPTURE_OVERRUN_EN
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %0d exp 0", overrun);
    end
`endif
  endtask

  task automatic test_ack_press();
    int n;
    press_enter(3'd6);
    press_enter(3'd4);
    press_enter(3'd2);
    switches = 4'b1101;
    n = 0;
    while (!m_press_next && n < 30) begin tick(); n++; end
    checks++;
    if (n >= 30) begin
      errors++;
      $display("FAIL ack_press_timeout got %0d clocks exp press within 30", n);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (phase !== 2'd0 || valid !== 1'b0 || in1 !== 3'd6 || in2 !== 3'd4) begin
      errors++;
      $display("FAIL ack_press got phase=%0d valid=%0d in1=%0d in2=%0d exp 0 0 6 4",
               phase, valid, in1, in2);
    end
`ifdef BTN_CAPTURE_OVERRUN_EN
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ack_press_overrun got %0d exp 0", overrun);
    end
`endif
    switches = 4'b0101;
    repeat (10) tick();
    checks++;
    if (phase !== 2'd0) begin
      errors++;
      $display("FAIL ack_press_dropped got phase=%0d exp 0", phase);
    end
  endtask

  task automatic test_reset_midop();
    press_enter(3'd3);
    checks++;
    if (phase !== 2'd1 || in1 !== 3'd3) begin
      errors++;
      $display("FAIL midop_first got phase=%0d in1=%0d exp 1 3", phase, in1);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (phase !== 2'd0 || in1 !== 3'd0) begin
      errors++;
      $display("FAIL midop_async got phase=%0d in1=%0d exp 0 0", phase, in1);
    end
    tick();
    reset = 1'b0;
    tick();
    press_enter(3'd2);
    press_enter(3'd4);
    checks++;
    if (phase !== 2'd2 || valid !== 1'b1 || in1 !== 3'd2 || in2 !== 3'd4) begin
      errors++;
      $display("FAIL midop_fresh got phase=%0d valid=%0d in1=%0d in2=%0d exp 2 1 2 4",
               phase, valid, in1, in2);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_random();
    int len;
    for (int seg = 0; seg < 300; seg++) begin
      switches = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 59) == 0);
      len = $urandom_range(1, 12);
      for (int t = 0; t < len; t++) begin
        ack = ($urandom_range(0, 3) == 0);
        tick();
        if (reset) reset = 1'b0;
        checks++;
        if (phase !== m_phase || in1 !== m_in1 || in2 !== m_in2 || valid !== m_valid) begin
          errors++;
          $display("FAIL random seg %0d got phase=%0d in1=%0d in2=%0d valid=%0d exp %0d %0d %0d %0d",
                   seg, phase, in1, in2, valid, m_phase, m_in1, m_in2, m_valid);
        end
`ifdef BTN_CAPTURE_OVERRUN_EN
        checks++;
        if (overrun !== m_ovr) begin
          errors++;
          $display("FAIL random_overrun seg %0d got %0d exp %0d", seg, overrun, m_ovr);
        end
`endif
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_bounce();
    test_overrun();
    test_ack_press();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
